// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, issues one request at a
//               time to instruction memory, holds the current instruction (IR)
//               plus one prefetched instruction (PF), and resolves branch and
//               jump redirects when the datapath consumes the IR.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    // instruction memory
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    // to control unit / datapath
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [2:0]         opcode,
    output logic [1:0]         funct2,
    output logic               instr_valid,
    input  logic               instr_ready,
    // branch resolution
    input  logic               blt,
    input  logic               bge,
    input  logic               jmp,
    input  logic               lt_flag,
    input  logic [ADDR_W-1:0]  branch_target
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,   // nothing outstanding, IR/PF empty
        S_REQ  = 3'd1,   // IR empty, request outstanding
        S_PREF = 3'd2,   // IR valid, prefetch outstanding
        S_FULL = 3'd3,   // IR and PF valid, memory idle
        S_DISC = 3'd4    // outstanding request whose data is thrown away
    } state_e;

    localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(PC_STEP);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic [INSTR_W-1:0] pf_q, pf_d;
    logic [ADDR_W-1:0]  pf_pc_q, pf_pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [ADDR_W-1:0]  redir_addr_q, redir_addr_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;

    logic               consume;
    logic               taken;
    logic [ADDR_W-1:0]  next_addr;

    // Branch outcome is only meaningful on the cycle the IR is consumed.
    assign consume   = valid_q & instr_ready;
    assign taken     = jmp | (blt & lt_flag) | (bge & ~lt_flag);
    // Wraps modulo 2^ADDR_W by construction.
    assign next_addr = req_addr_q + C_STEP;

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        ir_pc_d      = ir_pc_q;
        pf_d         = pf_q;
        pf_pc_d      = pf_pc_q;
        req_addr_d   = req_addr_q;
        redir_addr_d = redir_addr_q;

        unique case (state_q)
            S_BOOT: begin
                req_addr_d = RESET_PC;
                state_d    = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    ir_pc_d    = req_addr_q;
                    req_addr_d = next_addr;
                    state_d    = S_PREF;
                end
            end
            S_PREF: begin
                if (!consume) begin
                    if (imem_ack) begin
                        // Park the prefetch; req_addr moves on so it already
                        // points past PF when the IR is eventually consumed.
                        pf_d       = imem_rdata;
                        pf_pc_d    = req_addr_q;
                        req_addr_d = next_addr;
                        state_d    = S_FULL;
                    end
                end else if (!taken) begin
                    if (imem_ack) begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = req_addr_q;
                        req_addr_d = next_addr;
                    end else begin
                        // Same request keeps running, now as the IR fill.
                        state_d = S_REQ;
                    end
                end else begin
                    if (imem_ack) begin
                        req_addr_d = branch_target;
                        state_d    = S_REQ;
                    end else begin
                        // Address must stay stable until the stale ack.
                        redir_addr_d = branch_target;
                        state_d      = S_DISC;
                    end
                end
            end
            S_FULL: begin
                if (consume) begin
                    if (!taken) begin
                        ir_d    = pf_q;
                        ir_pc_d = pf_pc_q;
                        state_d = S_PREF;
                    end else begin
                        req_addr_d = branch_target;
                        state_d    = S_REQ;
                    end
                end
            end
            S_DISC: begin
                if (imem_ack) begin
                    req_addr_d = redir_addr_q;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase

        req_d   = (state_d == S_REQ) || (state_d == S_PREF) || (state_d == S_DISC);
        valid_d = (state_d == S_PREF) || (state_d == S_FULL);
    end

    // State, buffers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            ir_q         <= '0;
            ir_pc_q      <= RESET_PC;
            pf_q         <= '0;
            pf_pc_q      <= RESET_PC;
            req_addr_q   <= RESET_PC;
            redir_addr_q <= RESET_PC;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            pf_q         <= pf_d;
            pf_pc_q      <= pf_pc_d;
            req_addr_q   <= req_addr_d;
            redir_addr_q <= redir_addr_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = req_addr_q;
    assign instr       = ir_q;
    assign instr_pc    = ir_pc_q;
    assign instr_valid = valid_q;
    assign opcode      = ir_q[2:0];
    assign funct2      = ir_q[4:3];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A bench-side memory model
//               answers requests with data = f(addr) after a programmable
//               latency; a scoreboard of expected (pc, gap) entries is popped
//               on every consume. A second instance checks PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        int          gap;   // expected cycles since previous consume, 0 = skip
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  opcode;
    logic [1:0]  funct2;
    logic        instr_valid;
    logic        instr_ready;
    logic        blt, bge, jmp, lt_flag;
    logic [31:0] branch_target;

    // second instance, RESET_PC near the top of the address space
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic [2:0]  opcode2;
    logic [1:0]  funct2_2;
    logic        instr_valid2;

    exp_t        sb_q[$];
    logic [31:0] q2[$];

    int n_tests;
    int n_fail;
    int k;
    int last_cons_k;
    int lat;
    int mem_cnt;
    logic ready_en;
    logic stale_ack;
    logic br_armed;
    int   br_kind;          // 1 jmp, 2 blt, 3 bge
    logic br_lt;
    logic [31:0] br_pc;
    logic [31:0] br_tgt;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0007;
    endfunction

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .opcode       (opcode),
        .funct2       (funct2),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .blt          (blt),
        .bge          (bge),
        .jmp          (jmp),
        .lt_flag      (lt_flag),
        .branch_target(branch_target)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req2),
        .imem_addr    (imem_addr2),
        .imem_ack     (imem_ack2),
        .imem_rdata   (imem_rdata2),
        .instr        (instr2),
        .instr_pc     (instr_pc2),
        .opcode       (opcode2),
        .funct2       (funct2_2),
        .instr_valid  (instr_valid2),
        .instr_ready  (1'b1),
        .blt          (1'b0),
        .bge          (1'b0),
        .jmp          (1'b0),
        .lt_flag      (1'b0),
        .branch_target(32'h0)
    );

    // zero-wait memory for the wrap instance
    assign imem_ack2   = imem_req2;
    assign imem_rdata2 = mem_data(imem_addr2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (k=%0d)", tag, act, exp, k);
        end
    endtask

    task automatic push(input logic [31:0] pc, input int gap);
        exp_t e;
        e.pc  = pc;
        e.gap = gap;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs from the current outputs, score any consume,
    // then advance to #1 after the next rising edge.
    task automatic step();
        exp_t        e;
        logic [31:0] ei;
        logic [31:0] p2;
        logic [31:0] p_addr;
        logic        p_req, p_ack, p_rst;

        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        if (stale_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req === 1'b1 && mem_cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_data(imem_addr);
        end
        instr_ready   = ready_en;
        blt           = 1'b0;
        bge           = 1'b0;
        jmp           = 1'b0;
        lt_flag       = 1'b0;
        branch_target = 32'h0;
        if (br_armed && instr_valid === 1'b1 && instr_pc == br_pc) begin
            jmp           = (br_kind == 1);
            blt           = (br_kind == 2);
            bge           = (br_kind == 3);
            lt_flag       = br_lt;
            branch_target = br_tgt;
        end

        if (instr_valid === 1'b1 && instr_ready) begin
            check_eq("sb_have_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                ei = mem_data(e.pc);
                check_eq("instr_pc", instr_pc, e.pc);
                check_eq("instr", instr, ei);
                check_eq("opcode", 32'(opcode), 32'(ei[2:0]));
                check_eq("funct2", 32'(funct2), 32'(ei[4:3]));
                if (e.gap != 0 && last_cons_k >= 0)
                    check_eq("consume_gap", 32'(k - last_cons_k), 32'(e.gap));
            end
            last_cons_k = k;
            if (br_armed && instr_pc == br_pc) br_armed = 1'b0;
        end

        if (instr_valid2 === 1'b1 && q2.size() > 0) begin
            p2 = q2.pop_front();
            check_eq("wrap_pc", instr_pc2, p2);
            check_eq("wrap_instr", instr2, mem_data(p2));
        end

        p_addr  = imem_addr;
        p_req   = (imem_req === 1'b1);
        p_ack   = imem_ack;
        p_rst   = rst_n;
        mem_cnt = (p_req && !imem_ack) ? mem_cnt + 1 : 0;

        @(posedge clk);
        #1;
        k++;

        if (p_rst && p_req && !p_ack)
            check_eq("addr_hold", imem_addr, p_addr);
    endtask

    task automatic do_reset();
        ready_en  = 1'b0;
        br_armed  = 1'b0;
        stale_ack = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", instr_pc, 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_wrap_pc", instr_pc2, 32'hFFFF_FFFC);
        check_eq("rst_wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        rst_n       = 1'b1;
        k           = 0;
        last_cons_k = -1;
        mem_cnt     = 0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        k             = 0;
        last_cons_k   = -1;
        lat           = 0;
        mem_cnt       = 0;
        ready_en      = 1'b0;
        stale_ack     = 1'b0;
        br_armed      = 1'b0;
        br_kind       = 0;
        br_lt         = 1'b0;
        br_pc         = 32'h0;
        br_tgt        = 32'h0;
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        instr_ready   = 1'b0;
        blt           = 1'b0;
        bge           = 1'b0;
        jmp           = 1'b0;
        lt_flag       = 1'b0;
        branch_target = 32'h0;

        // zero-wait streaming, plus wrap instance sequence
        q2.push_back(32'hFFFF_FFFC);
        q2.push_back(32'h0000_0000);
        q2.push_back(32'h0000_0004);
        do_reset();
        ready_en = 1'b1;
        push(32'h0, 0); push(32'h4, 1); push(32'h8, 1); push(32'hC, 1);
        step();
        check_eq("c1_req", 32'(imem_req), 32'd1);
        check_eq("c1_addr", imem_addr, 32'h0);
        check_eq("c1_valid", 32'(instr_valid), 32'd0);
        step();
        while (k < 6) begin
            check_eq("thru_valid", 32'(instr_valid), 32'd1);
            step();
        end
        check_eq("s1_drained", 32'(sb_q.size()), 32'd0);
        check_eq("wrap_drained", 32'(q2.size()), 32'd0);

        // stall: FULL with memory idle, then back-to-back release
        do_reset();
        push(32'h0, 0); push(32'h4, 1); push(32'h8, 1);
        while (k < 7) step();
        check_eq("full_req", 32'(imem_req), 32'd0);
        check_eq("full_valid", 32'(instr_valid), 32'd1);
        check_eq("full_pc", instr_pc, 32'h0);
        ready_en = 1'b1;
        while (k < 10) step();
        check_eq("s2_drained", 32'(sb_q.size()), 32'd0);

        // jump at 0x8 to 0x40 with same-cycle ack
        do_reset();
        ready_en = 1'b1;
        br_armed = 1'b1; br_kind = 1; br_lt = 1'b0; br_pc = 32'h8; br_tgt = 32'h40;
        push(32'h0, 0); push(32'h4, 1); push(32'h8, 1); push(32'h40, 2); push(32'h44, 1);
        while (k < 5) step();
        check_eq("jmp_bubble_valid", 32'(instr_valid), 32'd0);
        check_eq("jmp_target_addr", imem_addr, 32'h40);
        while (k < 8) step();
        check_eq("s3_drained", 32'(sb_q.size()), 32'd0);

        // bge with lt=1: not taken
        do_reset();
        ready_en = 1'b1;
        br_armed = 1'b1; br_kind = 3; br_lt = 1'b1; br_pc = 32'h4; br_tgt = 32'h80;
        push(32'h0, 0); push(32'h4, 1); push(32'h8, 1); push(32'hC, 1);
        while (k < 6) step();
        check_eq("s4a_drained", 32'(sb_q.size()), 32'd0);

        // blt with lt=1: taken
        do_reset();
        ready_en = 1'b1;
        br_armed = 1'b1; br_kind = 2; br_lt = 1'b1; br_pc = 32'h4; br_tgt = 32'h80;
        push(32'h0, 0); push(32'h4, 1); push(32'h80, 2); push(32'h84, 1);
        while (k < 7) step();
        check_eq("s4b_drained", 32'(sb_q.size()), 32'd0);

        // 3-cycle memory, taken blt while prefetch outstanding -> discard
        do_reset();
        lat      = 2;
        ready_en = 1'b1;
        br_armed = 1'b1; br_kind = 2; br_lt = 1'b1; br_pc = 32'h4; br_tgt = 32'h100;
        push(32'h0, 0); push(32'h4, 3); push(32'h100, 6);
        while (k < 8) step();
        check_eq("disc_req", 32'(imem_req), 32'd1);
        check_eq("disc_addr_a", imem_addr, 32'h8);
        check_eq("disc_valid", 32'(instr_valid), 32'd0);
        step();
        check_eq("disc_addr_b", imem_addr, 32'h8);
        step();
        check_eq("redir_addr", imem_addr, 32'h100);
        while (k < 14) step();
        check_eq("s5_drained", 32'(sb_q.size()), 32'd0);

        // reset mid-request with a stale ack landing in BOOT
        do_reset();
        lat      = 2;
        ready_en = 1'b1;
        push(32'h0, 0); push(32'h4, 3);
        step();
        step();
        check_eq("pre_rst_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        step();
        check_eq("boot_req", 32'(imem_req), 32'd0);
        check_eq("boot_valid", 32'(instr_valid), 32'd0);
        rst_n     = 1'b1;
        stale_ack = 1'b1;
        step();
        stale_ack = 1'b0;
        check_eq("restart_req", 32'(imem_req), 32'd1);
        check_eq("restart_addr", imem_addr, 32'h0);
        check_eq("restart_valid", 32'(instr_valid), 32'd0);
        check_eq("restart_instr", instr, 32'h0);
        while (k < 11) step();
        check_eq("s6_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit in the unicycle core. Owns the PC, issues one-at-a-time requests to instruction memory, and buffers up to two instructions (current plus one prefetch). Presents the current instruction with its decoded `opcode`/`funct2` fields to the control unit. Resolves `bltp`/`bgep`/`jump` redirects when the datapath consumes the instruction, using the control unit's BLT/BGE/JMP strobes.

## Interface
- `ADDR_W`, 32, PC and memory address width
- `INSTR_W`, 32, instruction width
- `PC_STEP`, 4, PC increment per instruction
- `RESET_PC`, 0, first fetch address
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `imem_req` out 1: request outstanding
- `imem_addr` out ADDR_W: request address, stable while `imem_req`=1
- `imem_ack` in 1: one-cycle pulse, `imem_rdata` valid this cycle
- `imem_rdata` in INSTR_W: fetched instruction
- `instr` out INSTR_W: current instruction (IR)
- `instr_pc` out ADDR_W: address of `instr`
- `opcode` out 3: `instr[2:0]`, to control unit
- `funct2` out 2: `instr[4:3]`, to control unit
- `instr_valid` out 1: IR holds a valid instruction
- `instr_ready` in 1: datapath consumes IR this cycle
- `blt`, `bge`, `jmp` in 1 each: control unit branch strobes for IR
- `lt_flag` in 1: ALU compare result, rs1 < rs2
- `branch_target` in ADDR_W: redirect address

## Operation
- Consume = `instr_valid & instr_ready`. `taken = jmp | (blt & lt_flag) | (bge & ~lt_flag)`, sampled only on consume; otherwise ignored.
- Registers: IR + `ir_pc`, prefetch buffer PF + `pf_pc`, `req_addr`, `redir_addr`, `next_addr` (address of the next request).
- States:
  - BOOT: `req`=0, IR/PF empty.
  - REQ: IR empty, request for `req_addr` outstanding.
  - PREF: IR valid, prefetch request outstanding.
  - FULL: IR and PF valid, `req`=0.
  - DISC: request outstanding whose data must be discarded.
- BOOT → REQ unconditionally. `req_addr`=RESET_PC.
- REQ: on ack, IR←rdata and `ir_pc`←`req_addr`; `req_addr`←`req_addr`+PC_STEP; → PREF. No ack: stay, same address.
- PREF, transitions by (consume, taken, ack):
  - No consume, ack: PF←rdata → FULL.
  - No consume, no ack: stay.
  - Consume, not taken, ack: IR←rdata; `req_addr`+=PC_STEP; stay PREF.
  - Consume, not taken, no ack: → REQ, same `req_addr`.
  - Consume, taken, ack: drop rdata; `req_addr`←`branch_target` → REQ.
  - Consume, taken, no ack: `redir_addr`←`branch_target` → DISC.
- FULL:
  - Consume, not taken: IR←PF; new request at `req_addr` (already `pf_pc`+PC_STEP) → PREF.
  - Consume, taken: drop PF; `req_addr`←`branch_target` → REQ.
  - No consume: stay.
- DISC: `imem_addr` holds the old address until ack. On ack: discard data, `req_addr`←`redir_addr` → REQ.
- `instr_valid`=1 in PREF and FULL only. `imem_req`=1 in REQ, PREF and DISC.
- PC arithmetic is modulo 2^ADDR_W. Increment from all-ones wraps to 0 with no flag.
- `imem_ack` while `imem_req`=0 is ignored.

## Timing
- Reset values, all outputs: `imem_req`=0, `imem_addr`=RESET_PC, `instr`=0, `instr_pc`=RESET_PC, `instr_valid`=0. State=BOOT.
- Reset mid-operation: any outstanding request is abandoned. BOOT deasserts `imem_req` for one cycle, so a stale ack in BOOT is ignored.
- First request: cycle 1 after `rst_n` rises. With a same-cycle ack, `instr_valid`=1 in cycle 2.
- Throughput with zero-wait memory and `instr_ready` held 1: one instruction per cycle.
- Taken-branch bubble with zero-wait memory: `instr_valid`=0 for exactly one cycle, plus the remaining latency of any request that must be discarded.
- `opcode`/`funct2` are combinational slices of the IR register, with no added latency.
- `imem_addr` changes only in a cycle where `imem_req`=0 or `imem_ack`=1.

## Test plan
- Reset then zero-wait memory, `rdata`=addr, `instr_ready`=1: `instr_pc` sequence 0, 4, 8, 12, one per cycle. First `instr_valid` in cycle 2.
- `instr_ready`=0 for 5 cycles after the first instruction: FULL reached, `imem_req`=0. On release, instructions at 0 and 4 are delivered back-to-back with no gap and no duplicate.
- Consume at PC 8 with `jmp`=1, `branch_target`=0x40, ack same cycle: next `instr_pc`=0x40. The instruction at 0xC is never presented.
- `bge`=1, `lt_flag`=1 consumed: not taken, falls through to PC+4. `blt`=1, `lt_flag`=1: taken.
- 3-cycle memory latency, taken `bltp` consumed while a prefetch is outstanding: DISC holds `imem_addr` until ack, data is dropped, then a request to the target is issued.
- `rst_n` pulled low for one cycle while a request is outstanding, with ack arriving during BOOT: ack ignored, fetch restarts at RESET_PC.
- RESET_PC=0xFFFFFFFC: second fetch address wraps to 0x0.
